// File: rtl/mem_arbiter.sv
// Three-way arbiter (video, download FIFO, CPU) sharing one single-port synchronous RAM.
// Each access takes two cycles (ACCESS, DATA); a new grant can be issued on the edge leaving DATA.
module mem_arbiter (
    input  logic        clk42m,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic [7:0]  vid_dout,
    output logic        vid_valid,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic        dn_full,
    output logic        dn_overflow,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_DN} owner_t;

    state_t      state, state_next;
    owner_t      owner, grant;
    logic        owner_read;

    logic        vid_pend;
    logic [15:0] vid_addr_q;

    logic [15:0] fifo_addr [4];
    logic [7:0]  fifo_data [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic [1:0]  fair_cnt;

    logic        arb_edge;
    logic        vid_pending;
    logic        cpu_block;
    logic        cpu_pending;
    logic        dn_pending;
    logic        push, pop, drop;

    assign arb_edge    = (state == IDLE) || (state == DATA);
    assign vid_pending = vid_pend || vid_req;
    // The CPU is blocked on the edge that raises cpu_ack and while it is high.
    assign cpu_block   = cpu_ack || ((state == DATA) && (owner == OWN_CPU));
    assign cpu_pending = cpu_req && !cpu_block;
    assign dn_pending  = (count != 3'd0);

    assign pop     = (grant == OWN_DN);
    assign push    = dn_wr && ((count != 3'd4) || pop);
    assign drop    = dn_wr && (count == 3'd4) && !pop;
    assign dn_full = (count == 3'd4);

    always_ff @(posedge clk42m) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        grant      = OWN_NONE;
        state_next = state;
        case (state)
            IDLE, DATA: begin
                if (vid_pending)
                    grant = OWN_VID;
                else if (cpu_pending && ((fair_cnt == 2'd2) || !dn_pending))
                    grant = OWN_CPU;
                else if (dn_pending)
                    grant = OWN_DN;
                state_next = (grant == OWN_NONE) ? IDLE : ACCESS;
            end
            ACCESS:  state_next = DATA;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk42m) begin
        if (reset) begin
            owner       <= OWN_NONE;
            owner_read  <= 1'b0;
            cpu_dout    <= 8'h00;
            cpu_ack     <= 1'b0;
            vid_dout    <= 8'h00;
            vid_valid   <= 1'b0;
            dn_overflow <= 1'b0;
            ram_addr    <= 16'h0000;
            ram_we      <= 1'b0;
            ram_din     <= 8'h00;
            vid_pend    <= 1'b0;
            vid_addr_q  <= 16'h0000;
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            count       <= 3'd0;
            fair_cnt    <= 2'd0;
        end else begin
            cpu_ack   <= (state == DATA) && (owner == OWN_CPU);
            vid_valid <= (state == DATA) && (owner == OWN_VID);
            if ((state == DATA) && owner_read) begin
                if (owner == OWN_CPU)
                    cpu_dout <= ram_dout;
                if (owner == OWN_VID)
                    vid_dout <= ram_dout;
            end

            if (state == ACCESS)
                ram_we <= 1'b0;
            if (arb_edge)
                owner <= grant;

            case (grant)
                OWN_VID: begin
                    ram_addr   <= vid_req ? vid_addr : vid_addr_q;
                    ram_we     <= 1'b0;
                    owner_read <= 1'b1;
                end
                OWN_CPU: begin
                    ram_addr   <= cpu_addr;
                    ram_we     <= cpu_we;
                    ram_din    <= cpu_din;
                    owner_read <= !cpu_we;
                end
                OWN_DN: begin
                    ram_addr   <= fifo_addr[rd_ptr];
                    ram_we     <= 1'b1;
                    ram_din    <= fifo_data[rd_ptr];
                    owner_read <= 1'b0;
                end
                default: ;
            endcase

            if (vid_req)
                vid_addr_q <= vid_addr;
            if (grant == OWN_VID)
                vid_pend <= 1'b0;
            else if (vid_req)
                vid_pend <= 1'b1;

            // Two download grants in a row with the CPU waiting hand the next slot to the CPU.
            if (grant == OWN_CPU)
                fair_cnt <= 2'd0;
            else if (grant == OWN_DN)
                fair_cnt <= !cpu_req ? 2'd0 : (fair_cnt == 2'd2) ? 2'd2 : fair_cnt + 2'd1;

            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};
            if (drop)
                dn_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk42m) begin
        if (!reset && push) begin
            fifo_addr[wr_ptr] <= dn_addr;
            fifo_data[wr_ptr] <= dn_data;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM and write/ack monitors.
module tb_mem_arbiter;

    logic        clk42m = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic [7:0]  vid_dout;
    logic        vid_valid;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_full, dn_overflow;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;

    bit   [7:0]  mem [0:65535];
    int          wr_count  = 0;
    int          ack_count = 0;
    logic [23:0] wr_log [0:63];

    int          checks = 0;
    int          errors = 0;

    always #5 clk42m = ~clk42m;

    mem_arbiter dut (
        .clk42m      (clk42m),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_ack     (cpu_ack),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_dout    (vid_dout),
        .vid_valid   (vid_valid),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .dn_full     (dn_full),
        .dn_overflow (dn_overflow),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    always @(posedge clk42m) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (ram_we)
            mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // ram_we is high for exactly one cycle per write, so each high sample is one access.
    always @(posedge clk42m) begin
        if (ram_we) begin
            wr_log[wr_count[5:0]] <= {ram_addr, ram_din};
            wr_count <= wr_count + 1;
        end
        if (cpu_ack)
            ack_count <= ack_count + 1;
    end

    task automatic tick();
        @(posedge clk42m);
        #1;
    endtask

    task automatic applyStimulus(input logic c_req, input logic c_we, input logic [15:0] c_addr,
                                 input logic [7:0] c_din, input logic v_req, input logic [15:0] v_addr,
                                 input logic d_wr, input logic [15:0] d_addr, input logic [7:0] d_data);
        cpu_req  = c_req;
        cpu_we   = c_we;
        cpu_addr = c_addr;
        cpu_din  = c_din;
        vid_req  = v_req;
        vid_addr = v_addr;
        dn_wr    = d_wr;
        dn_addr  = d_addr;
        dn_data  = d_data;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 16'h0, 8'h0, 0, 16'h0, 0, 16'h0, 8'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wr0, ack0;
        int since_ack, dn_since, max_dn, max_gap, acks;
        bit started;

        reset = 1'b1;
        pre_we = 1'b1;
        pre_addr = 16'h4000;
        pre_data = 8'h5A;
        applyStimulus(1, 1, 16'h1111, 8'h11, 1, 16'h2222, 1, 16'h3333, 8'h33);
        pre_addr = 16'h3C00;
        pre_data = 8'hC3;
        applyStimulus(1, 1, 16'h1111, 8'h11, 1, 16'h2222, 1, 16'h3333, 8'h33);
        pre_we = 1'b0;
        checkOutput("reset_outputs", {cpu_dout, vid_dout, cpu_ack, vid_valid, ram_we, dn_full, dn_overflow}, 32'h0);
        checkOutput("reset_ram_bus", {ram_addr, ram_din}, 32'h0);

        // Inputs seen on the reset edge must leave nothing behind.
        reset = 1'b0;
        wr0 = wr_count;
        idle(4);
        checkOutput("reset_ignores_inputs", {vid_valid, cpu_ack, ram_addr}, 32'h0);
        checkOutput("reset_no_write", wr_count - wr0, 0);

        // CPU read on an idle arbiter
        wr0 = wr_count;
        ack0 = ack_count;
        applyStimulus(1, 0, 16'h4000, 8'h00, 0, 16'h0, 0, 16'h0, 8'h0);
        checkOutput("rd_addr_N", {ram_addr, 7'd0, ram_we, 7'd0, cpu_ack}, {16'h4000, 16'h0000});
        tick();
        checkOutput("rd_ack_N1", cpu_ack, 0);
        tick();
        checkOutput("rd_ack_N2", {cpu_ack, cpu_dout}, {1'b1, 8'h5A});
        idle(1);
        checkOutput("rd_ack_one_cycle", cpu_ack, 0);
        idle(4);
        checkOutput("rd_one_access", {ack_count - ack0, wr_count - wr0}, {32'd1, 32'd0});

        // Video, download and CPU all at once
        applyStimulus(1, 0, 16'h4000, 8'h00, 1, 16'h3C00, 1, 16'h5000, 8'hAA);
        checkOutput("sim_vid_grant", {ram_addr, 7'd0, ram_we}, {16'h3C00, 8'h00});
        applyStimulus(1, 0, 16'h4000, 8'h00, 0, 16'h0, 0, 16'h0, 8'h0);
        tick();
        checkOutput("sim_vid_valid", {vid_valid, vid_dout, cpu_ack}, {1'b1, 8'hC3, 1'b0});
        checkOutput("sim_dn_grant", {ram_addr, ram_din, 7'd0, ram_we}, {16'h5000, 8'hAA, 8'h01});
        tick();
        checkOutput("sim_vid_valid_off", {vid_valid, ram_we}, 0);
        tick();
        checkOutput("sim_cpu_grant", {ram_addr, 7'd0, ram_we}, {16'h4000, 8'h00});
        tick();
        checkOutput("sim_cpu_ack_N5", cpu_ack, 0);
        tick();
        checkOutput("sim_cpu_ack_N6", {cpu_ack, cpu_dout}, {1'b1, 8'h5A});
        idle(3);
        checkOutput("sim_dn_written", mem[16'h5000], 8'hAA);

        // Overflow while video keeps the RAM busy
        wr0 = wr_count;
        applyStimulus(0, 0, 16'h0, 8'h0, 1, 16'h3C00, 0, 16'h0, 8'h0);
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 0, 16'h0, 8'h0, 1, 16'h3C00, 1, 16'h5100 + 16'(i), 8'h10 + 8'(i));
        checkOutput("ovf_full_flag", {dn_full, dn_overflow}, 2'b11);
        checkOutput("ovf_no_write_yet", wr_count - wr0, 0);
        idle(12);
        checkOutput("ovf_drained", wr_count - wr0, 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("ovf_entry%0d", i), wr_log[(wr0 + i) % 64], {16'h5100 + 16'(i), 8'h10 + 8'(i)});
        checkOutput("ovf_sticky", {dn_full, dn_overflow}, 2'b01);
        checkOutput("vid_dout_hold", vid_dout, 8'hC3);

        // Fairness: CPU held against a continuous download stream
        since_ack = 0;
        dn_since = 0;
        max_dn = 0;
        max_gap = 0;
        acks = 0;
        started = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 0, 16'h2000, 8'h0, 0, 16'h0, 1, 16'h6000 + 16'(i), 8'(i));
            if (started)
                since_ack++;
            if (cpu_ack) begin
                acks++;
                if (started && since_ack > max_gap)
                    max_gap = since_ack;
                if (started && dn_since > max_dn)
                    max_dn = dn_since;
                started = 1;
                since_ack = 0;
                dn_since = 0;
            end
            if (ram_we && ram_addr[15:12] == 4'h6)
                dn_since++;
        end
        checkOutput("fair_max_dn_le2", max_dn <= 2, 1);
        checkOutput("fair_dn_progress", max_dn >= 1, 1);
        checkOutput("fair_gap_le6", max_gap <= 6, 1);
        checkOutput("fair_ack_count", acks >= 5, 1);
        idle(14);

        // Reset in the middle of a CPU write
        applyStimulus(1, 1, 16'h7000, 8'h99, 0, 16'h0, 1, 16'h5200, 8'h55);
        checkOutput("rst_write_grant", {ram_addr, ram_din, 7'd0, ram_we}, {16'h7000, 8'h99, 8'h01});
        reset = 1'b1;
        applyStimulus(1, 1, 16'h7000, 8'h99, 0, 16'h0, 0, 16'h0, 8'h0);
        reset = 1'b0;
        checkOutput("rst_outputs", {cpu_dout, vid_dout, cpu_ack, vid_valid, ram_we, dn_full, dn_overflow}, 32'h0);
        checkOutput("rst_ram_bus", {ram_addr, ram_din}, 32'h0);
        wr0 = wr_count;
        ack0 = ack_count;
        idle(8);
        checkOutput("rst_no_ack_no_write", {ack_count - ack0, wr_count - wr0}, 64'h0);

        // cpu_req held through the ack, then dropped
        wr0 = wr_count;
        ack0 = ack_count;
        applyStimulus(1, 1, 16'h1234, 8'h77, 0, 16'h0, 0, 16'h0, 8'h0);
        tick();
        tick();
        checkOutput("hold_ack", cpu_ack, 1);
        tick();
        checkOutput("hold_ack_drop", cpu_ack, 0);
        idle(6);
        checkOutput("hold_single_access", {ack_count - ack0, wr_count - wr0}, {32'd1, 32'd1});
        checkOutput("hold_mem", mem[16'h1234], 8'h77);
        checkOutput("hold_dout_unchanged", cpu_dout, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
